pipe_datapath: RTL and testbench

Parametrised two-stage pipelined register-file datapath: the next generation of the team's 32x32 regfile-plus-adder CPU core. It reads two operands from a `NREG`-entry register file (or takes the immediate `dataIn`), executes one of eight ALU operations, and writes the result back to a destination register and/or the output port. It adds a valid/ready issue handshake, a separate destination address, result forwarding or hazard stall, signed overflow with a sticky flag, and reset of all state.

---
 rtl/dp_pkg.sv | 26 ++
 rtl/dp_alu.sv | 36 +++
 rtl/pipe_datapath.sv | 143 ++++++++++++++
 tb/tb_pipe_datapath.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared definitions for the pipelined register-file datapath:
// ALU operation encodings and the signed-overflow rule.
package dp_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_XOR   = 3'd4,
        OP_PASSA = 3'd5,
        OP_PASSB = 3'd6,
        OP_SLT   = 3'd7
    } op_e;

    // Works on sign bits only, so it is independent of the datapath width.
    function automatic logic signed_overflow(input logic sign_a,
                                             input logic sign_b,
                                             input logic sign_r,
                                             input logic is_sub);
        logic signs_trigger;
        signs_trigger = is_sub ? (sign_a != sign_b) : (sign_a == sign_b);
        return signs_trigger && (sign_r != sign_a);
    endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational eight-function ALU with signed overflow flag.
module dp_alu
    import dp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] result,
    output logic             over
);

    always_comb begin
        result = '0;
        over   = 1'b0;
        case (op)
            OP_ADD: begin
                result = a + b;
                over   = signed_overflow(a[WIDTH-1], b[WIDTH-1], result[WIDTH-1], 1'b0);
            end
            OP_SUB: begin
                result = a - b;
                over   = signed_overflow(a[WIDTH-1], b[WIDTH-1], result[WIDTH-1], 1'b1);
            end
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_PASSA: result = a;
            OP_PASSB: result = b;
            OP_SLT:   result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/pipe_datapath.sv
// Two-stage (issue / EX) register-file datapath with valid/ready issue,
// EX-to-issue forwarding or one-cycle hazard stall, and sticky overflow.
module pipe_datapath
    import dp_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NREG   = 32,
    parameter int FWD_EN = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [$clog2(NREG)-1:0]   addressA,
    input  logic [$clog2(NREG)-1:0]   addressB,
    input  logic [$clog2(NREG)-1:0]   addressD,
    input  logic [WIDTH-1:0]          dataIn,
    input  logic                      asel,
    input  logic                      bsel,
    input  logic [2:0]                opsel,
    input  logic                      wen,
    input  logic                      oen,
    input  logic                      over_clr,
    output logic [WIDTH-1:0]          outPut,
    output logic                      out_valid,
    output logic                      over,
    output logic                      over_sticky
);

    localparam int AW = $clog2(NREG);

    logic [WIDTH-1:0] regs [NREG];

    logic             ex_valid;
    logic             ex_wen;
    logic             ex_oen;
    logic [AW-1:0]    ex_addressD;
    op_e              ex_op;
    logic [WIDTH-1:0] ex_a;
    logic [WIDTH-1:0] ex_b;

    logic [WIDTH-1:0] alu_result;
    logic             alu_over;

    logic             hazard_a;
    logic             hazard_b;
    logic             accept;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;

    assign hazard_a = ex_valid && ex_wen && asel && (addressA == ex_addressD);
    assign hazard_b = ex_valid && ex_wen && bsel && (addressB == ex_addressD);

    // Without forwarding, the bubble lets the EX write land before the re-read.
    assign in_ready = (FWD_EN != 0) ? 1'b1 : !(hazard_a || hazard_b);
    assign accept   = in_valid && in_ready;

    always_comb begin
        operand_a = regs[addressA];
        if (!asel) begin
            operand_a = dataIn;
        end else if ((FWD_EN != 0) && hazard_a) begin
            operand_a = alu_result;
        end
    end

    always_comb begin
        operand_b = regs[addressB];
        if (!bsel) begin
            operand_b = dataIn;
        end else if ((FWD_EN != 0) && hazard_b) begin
            operand_b = alu_result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_wen      <= 1'b0;
            ex_oen      <= 1'b0;
            ex_addressD <= '0;
            ex_op       <= OP_ADD;
            ex_a        <= '0;
            ex_b        <= '0;
        end else begin
            ex_valid <= accept;
            if (accept) begin
                ex_wen      <= wen;
                ex_oen      <= oen;
                ex_addressD <= addressD;
                ex_op       <= op_e'(opsel);
                ex_a        <= operand_a;
                ex_b        <= operand_b;
            end
        end
    end

    dp_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (ex_a),
        .b      (ex_b),
        .op     (ex_op),
        .result (alu_result),
        .over   (alu_over)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (ex_valid && ex_wen) begin
            regs[ex_addressD] <= alu_result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outPut    <= '0;
            out_valid <= 1'b0;
            over      <= 1'b0;
        end else begin
            out_valid <= ex_valid && ex_oen;
            if (ex_valid && ex_oen) begin
                outPut <= alu_result;
                over   <= alu_over;
            end
        end
    end

    // A new overflow takes priority over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            over_sticky <= 1'b0;
        end else if (ex_valid && ex_oen && alu_over) begin
            over_sticky <= 1'b1;
        end else if (over_clr) begin
            over_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_datapath.sv
// Self-checking bench: one forwarding and one stalling instance, each run
// through directed and random scenarios against a sequential ISA model.
module tb_pipe_datapath;
    import dp_pkg::*;

    localparam int N = 32;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  addressA = '0, addressB = '0, addressD = '0;
    logic [31:0] dataIn = '0;
    logic        asel = 1'b0, bsel = 1'b0, wen = 1'b0, oen = 1'b0, over_clr = 1'b0;
    logic [2:0]  opsel = '0;

    logic        v_f, v_s;
    logic        rdy_f, rdy_s, ov_f, ov_s, over_f, over_s, stk_f, stk_s;
    logic [31:0] out_f, out_s;
    logic        obs_rdy, obs_ov, obs_over, obs_stk;
    logic [31:0] obs_out;

    always #5 clk = ~clk;

    assign v_f = in_valid & ~sel;
    assign v_s = in_valid & sel;

    pipe_datapath #(.WIDTH(32), .NREG(N), .FWD_EN(1)) u_fwd (
        .clk(clk), .rst(rst), .in_valid(v_f), .in_ready(rdy_f),
        .addressA(addressA), .addressB(addressB), .addressD(addressD),
        .dataIn(dataIn), .asel(asel), .bsel(bsel), .opsel(opsel),
        .wen(wen), .oen(oen), .over_clr(over_clr),
        .outPut(out_f), .out_valid(ov_f), .over(over_f), .over_sticky(stk_f)
    );

    pipe_datapath #(.WIDTH(32), .NREG(N), .FWD_EN(0)) u_stall (
        .clk(clk), .rst(rst), .in_valid(v_s), .in_ready(rdy_s),
        .addressA(addressA), .addressB(addressB), .addressD(addressD),
        .dataIn(dataIn), .asel(asel), .bsel(bsel), .opsel(opsel),
        .wen(wen), .oen(oen), .over_clr(over_clr),
        .outPut(out_s), .out_valid(ov_s), .over(over_s), .over_sticky(stk_s)
    );

    always_comb begin
        obs_rdy = rdy_f; obs_ov = ov_f; obs_out = out_f; obs_over = over_f; obs_stk = stk_f;
        if (sel) begin
            obs_rdy = rdy_s; obs_ov = ov_s; obs_out = out_s; obs_over = over_s; obs_stk = stk_s;
        end
    end

    // Reference model: instructions complete in program order.
    logic [31:0] mregs [N];
    logic        pend_v, pend_wen, pend_oen, pend_over;
    logic [4:0]  pend_d;
    logic [31:0] pend_res;
    logic        exp_ov, exp_over, exp_sticky;
    logic [31:0] exp_out;
    logic        last_acc;
    int          stalls;
    logic [31:0] obs_log [$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [32:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, s;
        logic [31:0] r;
        logic ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ov = 1'b0;
        r  = '0;
        case (op)
            3'd0: begin s = sa + sb; r = s[31:0]; ov = (s > SMAX) || (s < SMIN); end
            3'd1: begin s = sa - sb; r = s[31:0]; ov = (s > SMAX) || (s < SMIN); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a;
            3'd6: r = b;
            default: r = (sa < sb) ? 32'd1 : 32'd0;
        endcase
        return {ov, r};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mregs[i] = '0;
        pend_v = 1'b0; pend_wen = 1'b0; pend_oen = 1'b0; pend_over = 1'b0;
        pend_d = '0; pend_res = '0;
        exp_ov = 1'b0; exp_out = '0; exp_over = 1'b0; exp_sticky = 1'b0;
    endtask

    // One clock: check ready, advance DUT and model, check outputs.
    task automatic cycle();
        logic haz, exp_rdy, acc;
        logic [31:0] a_val, b_val;
        #1;
        haz = pend_v && pend_wen && ((asel && addressA == pend_d) || (bsel && addressB == pend_d));
        exp_rdy = !sel || !haz;
        checks++;
        if (obs_rdy !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready: got %b expected %b (t=%0t)", obs_rdy, exp_rdy, $time);
        end
        acc = in_valid && exp_rdy;
        @(posedge clk);
        exp_ov = pend_v && pend_oen;
        if (exp_ov) begin
            exp_out  = pend_res;
            exp_over = pend_over;
        end
        if (pend_v && pend_oen && pend_over) exp_sticky = 1'b1;
        else if (over_clr) exp_sticky = 1'b0;
        if (pend_v && pend_wen) mregs[pend_d] = pend_res;
        pend_v = acc;
        if (acc) begin
            a_val = asel ? mregs[addressA] : dataIn;
            b_val = bsel ? mregs[addressB] : dataIn;
            {pend_over, pend_res} = ref_alu(opsel, a_val, b_val);
            pend_wen = wen;
            pend_oen = oen;
            pend_d   = addressD;
        end
        last_acc = acc;
        @(negedge clk);
        checks++;
        if (obs_ov !== exp_ov) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b (t=%0t)", obs_ov, exp_ov, $time);
        end
        checks++;
        if (obs_out !== exp_out) begin
            errors++;
            $display("FAIL outPut: got %h expected %h (t=%0t)", obs_out, exp_out, $time);
        end
        checks++;
        if (obs_over !== exp_over) begin
            errors++;
            $display("FAIL over: got %b expected %b (t=%0t)", obs_over, exp_over, $time);
        end
        checks++;
        if (obs_stk !== exp_sticky) begin
            errors++;
            $display("FAIL over_sticky: got %b expected %b (t=%0t)", obs_stk, exp_sticky, $time);
        end
        if (obs_ov === 1'b1) obs_log.push_back(obs_out);
    endtask

    task automatic issue(input op_e op, input logic as, input logic [4:0] a, input logic bs,
                         input logic [4:0] b, input logic [31:0] imm, input logic [4:0] d,
                         input logic we, input logic oe);
        opsel = op; asel = as; addressA = a; bsel = bs; addressB = b;
        dataIn = imm; addressD = d; wen = we; oen = oe;
        in_valid = 1'b1;
        stalls = 0;
        last_acc = 1'b0;
        for (int k = 0; k < 4 && !last_acc; k++) begin
            cycle();
            if (!last_acc) stalls++;
        end
        checks++;
        if (!last_acc) begin
            errors++;
            $display("FAIL issue_accept: got no accept expected accept within 4 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic hard_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        over_clr = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        issue(OP_ADD, 1'b0, 5'd0, 1'b0, 5'd0, 32'h7FFF_FFFF, 5'd7, 1'b1, 1'b1);
        idle(1);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs_out !== 32'h0 || obs_ov !== 1'b0 || obs_over !== 1'b0 || obs_stk !== 1'b0 || obs_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: got out=%h ov=%b over=%b stk=%b rdy=%b expected 0 0 0 0 1",
                     obs_out, obs_ov, obs_over, obs_stk, obs_rdy);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        obs_log.delete();
        issue(OP_PASSA, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b1);
        issue(OP_PASSA, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b1);
        idle(1);
        checks++;
        if (obs_log.size() != 2 || obs_log[0] !== 32'h0 || obs_log[1] !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: got n=%0d r5=%h r7=%h expected n=2 0 0",
                     obs_log.size(), obs_log[0], obs_log[1]);
        end
    endtask

    task automatic test_load_read();
        issue(OP_PASSB, 1'b0, 5'd0, 1'b0, 5'd0, 32'hFFFF_FFF6, 5'd0, 1'b1, 1'b0);
        issue(OP_PASSA, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b1);
        checks++;
        if (obs_ov !== 1'b0) begin
            errors++;
            $display("FAIL load_early_valid: got %b expected 0", obs_ov);
        end
        idle(1);
        checks++;
        if (obs_ov !== 1'b1 || obs_out !== 32'hFFFF_FFF6) begin
            errors++;
            $display("FAIL load_read: got ov=%b out=%h expected 1 fffffff6", obs_ov, obs_out);
        end
    endtask

    task automatic test_forwarding();
        int second_stalls;
        issue(OP_PASSB, 1'b0, 5'd0, 1'b0, 5'd0, 32'd10, 5'd1, 1'b1, 1'b0);
        issue(OP_PASSB, 1'b0, 5'd0, 1'b0, 5'd0, 32'd30, 5'd2, 1'b1, 1'b0);
        obs_log.delete();
        issue(OP_ADD, 1'b1, 5'd0, 1'b1, 5'd1, 32'h0, 5'd1, 1'b1, 1'b1);
        issue(OP_ADD, 1'b1, 5'd1, 1'b1, 5'd2, 32'h0, 5'd3, 1'b0, 1'b1);
        second_stalls = stalls;
        idle(2);
        checks++;
        if (second_stalls != (sel ? 1 : 0)) begin
            errors++;
            $display("FAIL fwd_stall_cycles: got %0d expected %0d", second_stalls, sel ? 1 : 0);
        end
        checks++;
        if (obs_log.size() != 2 || obs_log[0] !== 32'h0 || obs_log[1] !== 32'h1E) begin
            errors++;
            $display("FAIL fwd_results: got n=%0d %h %h expected n=2 0 1e",
                     obs_log.size(), obs_log[0], obs_log[1]);
        end
    endtask

    task automatic test_overflow();
        issue(OP_PASSB, 1'b0, 5'd0, 1'b0, 5'd0, 32'd1, 5'd1, 1'b1, 1'b0);
        issue(OP_ADD, 1'b0, 5'd0, 1'b1, 5'd1, 32'h7FFF_FFFF, 5'd0, 1'b0, 1'b1);
        idle(1);
        checks++;
        if (obs_out !== 32'h8000_0000 || obs_over !== 1'b1 || obs_stk !== 1'b1) begin
            errors++;
            $display("FAIL ovf_add: got out=%h over=%b stk=%b expected 80000000 1 1", obs_out, obs_over, obs_stk);
        end
        issue(OP_AND, 1'b0, 5'd0, 1'b1, 5'd1, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b1);
        idle(1);
        checks++;
        if (obs_out !== 32'h1 || obs_over !== 1'b0 || obs_stk !== 1'b1) begin
            errors++;
            $display("FAIL ovf_and_hold: got out=%h over=%b stk=%b expected 1 0 1", obs_out, obs_over, obs_stk);
        end
        over_clr = 1'b1;
        idle(1);
        over_clr = 1'b0;
        checks++;
        if (obs_stk !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", obs_stk);
        end
        issue(OP_SUB, 1'b0, 5'd0, 1'b1, 5'd1, 32'h8000_0000, 5'd0, 1'b0, 1'b1);
        over_clr = 1'b1;
        idle(1);
        over_clr = 1'b0;
        checks++;
        if (obs_out !== 32'h7FFF_FFFF || obs_over !== 1'b1 || obs_stk !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: got out=%h over=%b stk=%b expected 7fffffff 1 1", obs_out, obs_over, obs_stk);
        end
    endtask

    task automatic test_logic();
        issue(OP_PASSB, 1'b0, 5'd0, 1'b0, 5'd0, 32'd50, 5'd4, 1'b1, 1'b0);
        issue(OP_PASSB, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0000_F0F0, 5'd5, 1'b1, 1'b0);
        obs_log.delete();
        issue(OP_SLT, 1'b0, 5'd0, 1'b1, 5'd4, 32'hFFFF_FFF6, 5'd0, 1'b0, 1'b1);
        issue(OP_SLT, 1'b1, 5'd4, 1'b0, 5'd0, 32'hFFFF_FFF6, 5'd0, 1'b0, 1'b1);
        issue(OP_XOR, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0000_FF00, 5'd0, 1'b0, 1'b1);
        idle(2);
        checks++;
        if (obs_log.size() != 3 || obs_log[0] !== 32'd1 || obs_log[1] !== 32'd0 || obs_log[2] !== 32'h0FF0) begin
            errors++;
            $display("FAIL slt_xor: got n=%0d %h %h %h expected n=3 1 0 ff0",
                     obs_log.size(), obs_log[0], obs_log[1], obs_log[2]);
        end
        for (int k = 0; k < 8; k++) begin
            issue(k[0] ? OP_OR : OP_AND, 1'b1, 5'(k + 1), 1'b0, 5'd0, $urandom, 5'(k + 1), 1'b1, 1'b1);
        end
        idle(1);
    endtask

    task automatic test_random();
        op_e op;
        logic [31:0] imm;
        for (int k = 0; k < 250; k++) begin
            op = op_e'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: imm = 32'h7FFF_FFFF;
                1: imm = 32'h8000_0000;
                default: imm = $urandom;
            endcase
            over_clr = ($urandom_range(0, 7) == 0);
            issue(op, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3)),
                  imm,
                  ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        over_clr = 1'b0;
        idle(1);
    endtask

    task automatic test_readback();
        int bad;
        bad = 0;
        obs_log.delete();
        for (int r = 0; r < N; r++) begin
            issue(OP_PASSA, 1'b1, 5'(r), 1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b1);
        end
        idle(1);
        checks++;
        if (obs_log.size() != N) begin
            errors++;
            $display("FAIL readback_count: got %0d expected %0d", obs_log.size(), N);
        end else begin
            for (int r = 0; r < N; r++) if (obs_log[r] !== mregs[r]) bad++;
            if (bad != 0) begin
                errors++;
                $display("FAIL readback_regs: got %0d differing registers expected 0", bad);
            end
        end
    endtask

    task automatic test_reset_in_flight();
        logic seen_ov;
        issue(OP_PASSB, 1'b0, 5'd0, 1'b0, 5'd0, 32'h1234, 5'd3, 1'b1, 1'b1);
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1 seen_ov = obs_ov;
        @(negedge clk);
        seen_ov = seen_ov | obs_ov;
        rst = 1'b0;
        checks++;
        if (seen_ov !== 1'b0) begin
            errors++;
            $display("FAIL inflight_valid: got %b expected 0", seen_ov);
        end
        obs_log.delete();
        issue(OP_PASSA, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b1);
        idle(1);
        checks++;
        if (obs_log.size() != 1 || obs_log[0] !== 32'h0) begin
            errors++;
            $display("FAIL inflight_r3: got n=%0d %h expected n=1 0", obs_log.size(), obs_log[0]);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            sel = p[0];
            hard_reset();
            test_reset();
            test_load_read();
            test_forwarding();
            test_overflow();
            test_logic();
            test_random();
            test_readback();
            test_reset_in_flight();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
